// File: rtl/alu_op_pkg.sv
// alu_op_pkg
//   Shared types for the iterative EX-stage ALU: the 4-bit operation code
//   enum, the shift-op helper and the execution FSM state enum.
package alu_op_pkg;

   typedef enum logic [3:0] {
      ALU_AND   = 4'b0000,
      ALU_OR    = 4'b0001,
      ALU_ADD   = 4'b0010,
      ALU_SUB   = 4'b0011,
      ALU_XOR   = 4'b0100,
      ALU_SRL   = 4'b0101,
      ALU_PASSB = 4'b0111,
      ALU_EQ    = 4'b1000,
      ALU_SLT   = 4'b1100,
      ALU_SLL   = 4'b1110,
      ALU_SRA   = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } alu_iter_state_e;

   function automatic logic is_shift(alu_op_e op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_basic_ops.sv
// alu_basic_ops
//   Combinational single-cycle ALU operations and undefined-code decode.
//   Shift codes are handled by the iterating top level; here they return 0
//   without flagging an error.
// Ports:
//   op      in   operation code
//   a, b    in   operands
//   res     out  single-cycle result
//   op_err  out  op is not a defined code
module alu_basic_ops
   import alu_op_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [3:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] res,
   output logic                  op_err
);

   always_comb begin
      res    = '0;
      op_err = 1'b0;
      case (alu_op_e'(op))
         ALU_AND:   res = a & b;
         ALU_OR:    res = a | b;
         ALU_ADD:   res = a + b;
         ALU_SUB:   res = a - b;
         ALU_XOR:   res = a ^ b;
         ALU_PASSB: res = b;
         ALU_EQ:    res = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
         ALU_SLT:   res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SRL, ALU_SLL, ALU_SRA: res = '0;
         default:   op_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_iter_exec.sv
// alu_iter_exec
//   EX-stage ALU with valid/ready handshakes. Single-cycle ops finish on the
//   accept edge; shifts step one bit per cycle, stalling the pipeline.
// Ports:
//   clk, reset          clock, async active-high reset
//   flush               synchronous abort of any in-flight op
//   in_valid/in_ready   input handshake (ready only in IDLE)
//   Operation, src_a, src_b  op code and operands, sampled at accept
//   out_valid/out_ready output handshake (valid only in DONE)
//   result, zero, op_err     registered outputs, held while in DONE
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// SHIFT | shifting acc one bit per cycle, cnt counts down
// DONE  | result presented, waiting for out_ready
module alu_iter_exec
   import alu_op_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero,
   output logic                  op_err
);

   localparam int SHW = $clog2(DATA_WIDTH);
   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

   alu_iter_state_e       state_q;
   alu_op_e               op_q;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]        cnt_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  zero_q, op_err_q;

   logic [DATA_WIDTH-1:0] basic_res;
   logic                  basic_err;
   logic [SHW-1:0]        shamt;
   alu_op_e               op_in;

   assign shamt = src_b[SHW-1:0];
   assign op_in = alu_op_e'(Operation);

   alu_basic_ops #(.DATA_WIDTH(DATA_WIDTH)) u_basic (
      .op     (Operation),
      .a      (src_a),
      .b      (src_b),
      .res    (basic_res),
      .op_err (basic_err)
   );

   // One-bit shift step; SRA replicates the current MSB, which is the
   // original sign since every step preserves it.
   always_comb begin
      acc_d = acc_q;
      case (op_q)
         ALU_SLL: acc_d = {acc_q[DATA_WIDTH-2:0], 1'b0};
         ALU_SRL: acc_d = {1'b0, acc_q[DATA_WIDTH-1:1]};
         ALU_SRA: acc_d = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
         default: acc_d = acc_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= ALU_AND;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         op_err_q <= 1'b0;
      end else if (flush) begin
         // A DONE-state transfer in this cycle still completes: the
         // downstream sampled it, and going to IDLE is the same either way.
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (is_shift(op_in) && (shamt != '0)) begin
                     acc_q   <= src_a;
                     cnt_q   <= shamt;
                     op_q    <= op_in;
                     state_q <= SHIFT;
                  end else if (is_shift(op_in)) begin
                     result_q <= src_a;
                     zero_q   <= (src_a == '0);
                     op_err_q <= 1'b0;
                     state_q  <= DONE;
                  end else begin
                     result_q <= basic_res;
                     zero_q   <= (basic_res == '0);
                     op_err_q <= basic_err;
                     state_q  <= DONE;
                  end
               end
            end
            SHIFT: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  result_q <= acc_d;
                  zero_q   <= (acc_d == '0);
                  op_err_q <= 1'b0;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// tb_alu_iter_exec
//   Scoreboard bench: expected results from a direct (non-iterative) model
//   are queued when an op is driven and popped when a transfer is seen.
module tb_alu_iter_exec;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  Operation = 4'b0000;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        zero;
   logic        op_err;

   int   n_chk = 0;
   int   n_fail = 0;
   int   n_xfer = 0;
   int   n_pushed = 0;
   exp_t exp_q[$];

   alu_iter_exec #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .op_err    (op_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [4:0] sh;
      sh    = b[4:0];
      e.err = 1'b0;
      case (op)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0010: e.res = a + b;
         4'b0011: e.res = a - b;
         4'b0100: e.res = a ^ b;
         4'b0101: e.res = a >> sh;
         4'b0111: e.res = b;
         4'b1000: e.res = (a == b) ? 32'd1 : 32'd0;
         4'b1100: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1110: e.res = a << sh;
         4'b1111: e.res = 32'($signed(a) >>> sh);
         default: begin e.res = '0; e.err = 1'b1; end
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
      if ((op == 4'b0101 || op == 4'b1110 || op == 4'b1111) && b[4:0] != 5'd0)
         return 1 + int'(b[4:0]);
      return 1;
   endfunction

   // Transfer monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         n_xfer++;
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'(out_valid), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", 64'(result), 64'(e.res));
            chk("zero", 64'(zero), 64'(e.z));
            chk("op_err", 64'(op_err), 64'(e.err));
         end
      end
   end

   // Issue one op, check latency and busy behaviour, optionally stall output.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int bp);
      int          k;
      logic        rdy_bad;
      logic [31:0] hold;
      @(posedge clk); #1;
      chk("ready_before", 64'(in_ready), 64'd1);
      Operation = op; src_a = a; src_b = b; in_valid = 1'b1;
      out_ready = (bp == 0);
      exp_q.push_back(model(op, a, b));
      n_pushed++;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      src_a     = $urandom;
      src_b     = $urandom;
      Operation = 4'($urandom);
      k = 1; rdy_bad = 1'b0;
      while (!out_valid && k < 100) begin
         if (in_ready) rdy_bad = 1'b1;
         @(posedge clk); #1;
         k++;
      end
      chk("latency", 64'(k), 64'(exp_lat(op, b)));
      chk("busy_ready_low", 64'(rdy_bad | in_ready), 64'd0);
      if (bp > 0) begin
         hold = result;
         repeat (bp) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_hold", 64'(result), 64'(hold));
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("ready_after", 64'(in_ready), 64'd1);
      chk("valid_after", 64'(out_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_zero", 64'(zero), 64'd1);
      chk("rst_err", 64'(op_err), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      do_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
      do_op(4'b0011, 32'd5, 32'd5, 0);
      do_op(4'b1100, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(4'b1000, 32'h1234, 32'h1234, 0);
      do_op(4'b0111, 32'h5555_5555, 32'hABCD_0000, 0);
      do_op(4'b1111, 32'h8000_0000, 32'd31, 0);
      do_op(4'b1110, 32'hDEAD_BEEF, 32'h0000_0020, 0);
      do_op(4'b0101, 32'h0000_00F0, 32'd4, 5);
      do_op(4'b0110, 32'h1111_1111, 32'h2222_2222, 0);
      do_op(4'b0010, 32'd3, 32'd4, 0);
      do_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
      do_op(4'b0001, 32'h0F00_0000, 32'h0000_00F0, 0);
      do_op(4'b0100, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0);
      do_op(4'b1000, 32'd1, 32'd2, 0);
      do_op(4'b1100, 32'd7, 32'hFFFF_FFF0, 0);
      do_op(4'b1110, 32'd1, 32'd31, 0);
      do_op(4'b0101, 32'h8000_0001, 32'd1, 0);
      do_op(4'b1111, 32'h4000_0000, 32'd3, 0);
      do_op(4'b1011, 32'd9, 32'd9, 0);

      // Flush in the 3rd SHIFT cycle of SLL by 10, with a competing in_valid.
      @(posedge clk); #1;
      Operation = 4'b1110; src_a = 32'h1; src_b = 32'd10; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("flush_busy", 64'(in_ready), 64'd0);
      flush = 1'b1; in_valid = 1'b1; Operation = 4'b0010; src_a = 32'd1; src_b = 32'd1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_ready", 64'(in_ready), 64'd1);
      chk("flush_valid", 64'(out_valid), 64'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("flush_idle", 64'(in_ready), 64'd1);

      // Asynchronous reset in the middle of an SRA by 20.
      @(posedge clk); #1;
      Operation = 4'b1111; src_a = 32'h8000_00FF; src_b = 32'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_result", 64'(result), 64'd0);
      chk("mid_rst_zero", 64'(zero), 64'd1);
      chk("mid_rst_err", 64'(op_err), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      chk("post_rst_valid", 64'(out_valid), 64'd0);

      do_op(4'b0011, 32'd10, 32'd3, 0);

      repeat (2) @(posedge clk);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      chk("xfer_count", 64'(n_xfer), 64'(n_pushed));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execution-side consumer of the 4-bit ALU operation code produced by the ALU control decode.
- Sits in the EX stage between the operand muxes and the EX/MEM writeback path.
- Logic ops, add/sub, compare, equality and pass-B complete in 1 cycle.
- Shifts iterate 1 bit per cycle, for area.
- valid/ready handshake on input and output, so the pipeline stalls on multi-cycle shifts.

Parameters:
- DATA_WIDTH, 32, operand and result width; shift amount width is SHW = $clog2(DATA_WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort of any in-flight operation
- in_valid  input  1  operands and Operation valid
- in_ready  output  1  block can accept; high only in IDLE
- Operation  input  4  ALU operation code
- src_a  input  DATA_WIDTH  operand A
- src_b  input  DATA_WIDTH  operand B; shift amount is src_b[SHW-1:0]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  DATA_WIDTH  ALU result, held stable while out_valid && !out_ready
- zero  output  1  result == 0
- op_err  output  1  Operation was an undefined code; qualified by out_valid

Behaviour:
- Operation encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB; 0100 XOR
  - 0101 SRL; 0111 PASS_B (result = src_b); 1000 EQ (result = {0, A==B})
  - 1100 SLT (signed, result = {0, A<B}); 1110 SLL; 1111 SRA
- All other codes: result = 0, op_err = 1, single-cycle latency.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- Accept on in_valid && in_ready at edge T:
  - Non-shift op: result registered at T, state -> DONE; out_valid is high in cycle T+1.
  - Shift op with shamt == 0: result = src_a, -> DONE; same latency as non-shift.
  - Shift op with shamt = n > 0: acc = src_a, cnt = n, op latched, -> SHIFT.
- SHIFT, each cycle:
  - acc shifted by 1: SLL fills 0; SRL fills 0; SRA fills the latched sign bit acc[MSB].
  - cnt decrements.
  - When cnt == 1 at the edge, state -> DONE with the final value.
  - out_valid first high in cycle T+1+n. Maximum latency is DATA_WIDTH for shamt = DATA_WIDTH-1.
- DONE:
  - result, zero and op_err are held.
  - On out_valid && out_ready -> IDLE; the next accept is possible 1 cycle later. There is no accept in the DONE cycle.
- flush (any state): next state IDLE, cnt cleared, out_valid low next cycle. result keeps its last value.
  - flush && in_valid in the same cycle: flush wins, nothing is accepted.
  - flush && out_valid && out_ready in the same cycle: the transfer counts as done; state -> IDLE.
- Inputs are sampled only at accept. Changes to src_a, src_b or Operation during SHIFT/DONE have no effect.
- Reset (asynchronous, any state, including mid-shift): state = IDLE, result = 0, zero = 1, op_err = 0, out_valid = 0, cnt = 0, acc = 0.
  - in_ready is 1 after reset.
  - An in-flight shift is discarded.
- zero and op_err are registered alongside result, not combinational from result.

Decomposition:
- Package alu_op_pkg:
  - typedef enum logic [3:0] alu_op_e: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_SRL, ALU_PASSB, ALU_EQ, ALU_SLT, ALU_SLL, ALU_SRA, with the codes above.
  - Function is_shift(alu_op_e).
  - typedef enum alu_iter_state_e {IDLE, SHIFT, DONE}.
- Sub-module alu_basic_ops: purely combinational; covers the single-cycle ops and the op_err decode.
- The top level holds the FSM, acc/cnt registers, shift step and output registers.

Test Plan:
- ADD A=0x7FFFFFFF, B=1 -> out_valid at T+1, result 0x80000000, zero=0. SUB A=5, B=5 -> result 0, zero=1.
- SLT A=0xFFFFFFFF, B=1 -> result 1. EQ A=B=0x1234 -> result 1. PASS_B B=0xABCD0000 -> result 0xABCD0000.
- SRA A=0x80000000, B=31 -> out_valid first at T+32, result 0xFFFFFFFF, in_ready low T+1..T+32. SLL shamt 0 -> T+1, result = A.
- Backpressure: SRL A=0xF0, B=4, out_ready held low 5 cycles -> result 0x0F stable, single transfer, then in_ready high the following cycle.
- flush asserted in the 3rd SHIFT cycle of SLL B=10 together with in_valid -> no out_valid, nothing accepted, in_ready high next cycle. Reset mid-shift -> all outputs at reset values.
- Operation 0110 -> result 0, op_err=1 at T+1. Next ADD clears op_err.
